header_capture_buffer: RTL
==========================

// Module: header_capture_buffer
// PURPOSE
//  Parametrised successor to the fixed 18-byte header grabber. Sniffs accepted AXI-Stream beats and packs
//  the first HDR_BYTES bytes of each frame, MSB lane first, honouring tkeep. Detects frame boundaries from tlast.
//  Presents the header on a valid/ready handshake and flags short frames and overruns.
//  Sits between the ingress AXIS tap and the field extractor / classifier.
// PARAMETERS
//  DATA_WIDTH  64  stream width in bits; multiple of 8, >= 8
//  HDR_BYTES   18  bytes captured per frame, >= 1 (18 = DA+SA+802.1Q tag; 22 for QinQ)
//  KEEP_WIDTH  DATA_WIDTH/8  derived localparam, not overridable
// PORTS
//  clk           in   1                clock, all logic on rising edge
//  rst           in   1                synchronous reset, active-high
//  beat_accept   in   1                tvalid & tready of monitored stream (beat transferred this cycle)
//  axis_tdata    in   DATA_WIDTH       beat data; lane i = tdata[DATA_WIDTH-1-8i -: 8]
//  axis_tkeep    in   KEEP_WIDTH       lane i qualified by tkeep[KEEP_WIDTH-1-i]
//  axis_tlast    in   1                last beat of frame
//  hdr_bytes     out  HDR_BYTES x 8    packed [HDR_BYTES-1:0][7:0]; element 0 = first frame byte
//  hdr_len       out  $clog2(HDR_BYTES+1)  bytes actually captured (HDR_BYTES unless short)
//  hdr_short     out  1                frame ended before HDR_BYTES bytes
//  hdr_valid     out  1                header record available
//  hdr_ready     in   1                consumer accepts record when hdr_valid & hdr_ready
//  hdr_overrun   out  1                one-cycle pulse: frame began while a record was still unconsumed
// BEHAVIOUR
//  Reset (rst=1 at clock edge): state=IDLE, hdr_bytes=0, hdr_len=0, hdr_short=0, hdr_valid=0, hdr_overrun=0,
//   frame_open=0, skip=0. Reset wins over every other input, including mid-capture and mid-HOLD.
//  Frame start: first beat_accept after reset or after a beat with tlast. No external frame_start port.
//  States:
//   IDLE    - no frame open. Start beat -> clear hdr_bytes to 0, pack beat -> CAPTURE, or HOLD if header done.
//   CAPTURE - each beat_accept appends kept lanes, in lane order, at hdr_len until HDR_BYTES reached.
//             Sparse tkeep is compacted; excess bytes of the completing beat are discarded.
//             hdr_len reaches HDR_BYTES -> HOLD (frame_open = !tlast).
//             tlast before full -> HOLD, hdr_short=1, frame_open=0.
//   HOLD    - hdr_valid=1, outputs stable until handshake. Beats of the current frame are ignored.
//             A tlast beat only clears frame_open. On handshake: -> DRAIN if frame_open, else IDLE.
//   DRAIN   - header delivered, frame still open. Beats ignored; tlast beat -> IDLE.
//  Latency: hdr_valid rises the cycle after the completing (or tlast) beat, i.e. registered, 1 cycle.
//  hdr_valid drops the cycle after handshake. A back-to-back new frame is accepted in IDLE on that same next cycle.
//  Overrun: start beat arrives in HOLD with frame_open=0 -> hdr_overrun pulses next cycle, skip=1.
//   That frame is not captured; skip clears on its tlast. Held record is never corrupted.
//  Handshake and an overrun start beat in the same cycle: handshake completes, and the new frame is still
//   skipped (no same-cycle re-capture).
//  Zero-keep beat (tkeep=0): counts as a beat (frame start, tlast) but appends nothing.
//   A zero-keep start+tlast beat yields hdr_len=0, hdr_short=1.
//  Single-beat frame that fills the header with tlast=1: HOLD with frame_open=0, hdr_short=0.
//  hdr_len width $clog2(HDR_BYTES+1); internal append index saturates at HDR_BYTES, never wraps.
//  Bytes beyond hdr_len in a short record read 0.
// STRUCTURE
//  etherparse_pkg: ETH_HDR_BYTES=18, ETH_HDR_BYTES_QINQ=22, typedef enum logic [1:0] hdr_cap_state_t
//   {HC_IDLE, HC_CAPTURE, HC_HOLD, HC_DRAIN}.
//  Sub-module keep_lane_compactor (combinational): tdata+tkeep -> packed byte vector + popcount.
//   Instantiated once; top owns FSM, append index, record registers.
// TESTING (DATA_WIDTH=64, HDR_BYTES=18 unless stated)
//  1 Three full beats 00..17 (tkeep=FF), tlast on 3rd, hdr_ready=1 -> hdr_valid 1 cycle after beat 3;
//    hdr_bytes[0]=00, [17]=11, hdr_len=18, hdr_short=0; bytes 18..23 discarded.
//  2 Short frame: beat1 keep=FF, beat2 keep=F0 + tlast -> hdr_len=12, hdr_short=1, hdr_bytes[12..17]=0.
//  3 Backpressure: hdr_ready=0 for 10 cycles; next frame starts after 1st tlast -> hdr_overrun 1-cycle pulse.
//    Record unchanged. Frame after that, with hdr_ready=1, is captured normally.
//  4 Sparse keep: beat keep=A5 -> lanes 0,2,5,7 packed consecutively into hdr_bytes[0..3].
//  5 Reset asserted in CAPTURE after 1 beat -> all outputs 0 next cycle.
//    Next beat treated as frame start (hdr_bytes[0] = its lane 0).
//  6 DATA_WIDTH=32, HDR_BYTES=22, 8-beat frame, hdr_ready pulsed on valid -> hdr_len=22.
//    DRAIN until tlast, then IDLE; back-to-back frame captured with no gap.

Source files
------------

// File: rtl/etherparse_pkg.sv
// Shared types and constants for the Ethernet header parsing blocks.
package etherparse_pkg;

  localparam int unsigned ETH_HDR_BYTES      = 18;
  localparam int unsigned ETH_HDR_BYTES_QINQ = 22;

  typedef enum logic [1:0] {
    HC_IDLE,
    HC_CAPTURE,
    HC_HOLD,
    HC_DRAIN
  } hdr_cap_state_t;

  // Add with saturation at lim; keeps the append index from wrapping.
  function automatic int unsigned sat_add(input int unsigned base, input int unsigned inc,
                                          input int unsigned lim);
    return ((base + inc) >= lim) ? lim : (base + inc);
  endfunction

endpackage

// File: rtl/header_capture_buffer_if.sv
// Monitored AXI-Stream beat plus header-record handshake for header_capture_buffer.
interface header_capture_buffer_if
  import etherparse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_BYTES  = ETH_HDR_BYTES
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LEN_W      = $clog2(HDR_BYTES + 1);

  logic                          beat_accept;
  logic [DATA_WIDTH-1:0]         axis_tdata;
  logic [KEEP_WIDTH-1:0]         axis_tkeep;
  logic                          axis_tlast;
  logic [HDR_BYTES-1:0][7:0]     hdr_bytes;
  logic [LEN_W-1:0]              hdr_len;
  logic                          hdr_short;
  logic                          hdr_valid;
  logic                          hdr_ready;
  logic                          hdr_overrun;

  modport master (
    output beat_accept, axis_tdata, axis_tkeep, axis_tlast, hdr_ready,
    input  hdr_bytes, hdr_len, hdr_short, hdr_valid, hdr_overrun
  );

  modport slave (
    input  beat_accept, axis_tdata, axis_tkeep, axis_tlast, hdr_ready,
    output hdr_bytes, hdr_len, hdr_short, hdr_valid, hdr_overrun
  );

endinterface

// File: rtl/keep_lane_compactor.sv
// Packs the tkeep-qualified lanes of one beat into consecutive bytes (lane 0 first) and counts them.
module keep_lane_compactor #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]                tdata,
  input  logic [DATA_WIDTH/8-1:0]              tkeep,
  output logic [DATA_WIDTH/8-1:0][7:0]         bytes_c,
  output logic [$clog2(DATA_WIDTH/8+1)-1:0]    count_c
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W      = $clog2(KEEP_WIDTH + 1);
  localparam int unsigned KIDX_W     = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

  always_comb begin
    int unsigned n;
    bytes_c = '0;
    n       = 0;
    for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
      if (tkeep[KIDX_W'(int'(KEEP_WIDTH) - 1 - i)]) begin
        bytes_c[KIDX_W'(n)] = 8'(tdata >> (DATA_WIDTH - 8 - 8 * i));
        n = n + 1;
      end
    end
    count_c = CNT_W'(n);
  end

endmodule

// File: rtl/header_capture_buffer.sv
// Captures the first HDR_BYTES bytes of each monitored frame and offers them as one record.
module header_capture_buffer
  import etherparse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_BYTES  = ETH_HDR_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  header_capture_buffer_if.slave   bus
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LEN_W      = $clog2(HDR_BYTES + 1);
  localparam int unsigned CNT_W      = $clog2(KEEP_WIDTH + 1);
  localparam int unsigned KIDX_W     = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;
  localparam int unsigned HIDX_W     = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

  hdr_cap_state_t            state, state_n;
  logic                      frame_open, frame_open_n;
  logic                      skip, skip_n;
  logic [HDR_BYTES-1:0][7:0] bytes_q, bytes_n;
  logic [LEN_W-1:0]          len_q, len_n;
  logic                      short_q, short_n;
  logic                      valid_q, valid_n;
  logic                      overrun_q, overrun_n;

  logic [KEEP_WIDTH-1:0][7:0] packed_c;
  logic [CNT_W-1:0]           count_c;
  logic [HDR_BYTES-1:0][7:0]  app_bytes_c;
  logic [LEN_W-1:0]           app_len_c;

  keep_lane_compactor #(.DATA_WIDTH(DATA_WIDTH)) u_compactor (
    .tdata   (bus.axis_tdata),
    .tkeep   (bus.axis_tkeep),
    .bytes_c (packed_c),
    .count_c (count_c)
  );

  // Record as it would look after appending this beat; a new frame starts from an empty record.
  always_comb begin
    logic [LEN_W-1:0] base_len;
    int               rel;
    base_len    = (state == HC_IDLE) ? '0 : len_q;
    app_bytes_c = (state == HC_IDLE) ? '0 : bytes_q;
    for (int k = 0; k < int'(HDR_BYTES); k++) begin
      rel = k - int'(base_len);
      if (rel >= 0 && rel < int'(count_c)) begin
        app_bytes_c[HIDX_W'(k)] = packed_c[KIDX_W'(rel)];
      end
    end
    app_len_c = LEN_W'(sat_add(32'(base_len), 32'(count_c), HDR_BYTES));
  end

  always_comb begin
    logic take;
    state_n      = state;
    frame_open_n = frame_open;
    skip_n       = skip;
    bytes_n      = bytes_q;
    len_n        = len_q;
    short_n      = short_q;
    overrun_n    = 1'b0;
    take         = 1'b0;

    unique case (state)
      HC_IDLE: begin
        if (bus.beat_accept) begin
          if (skip) begin
            if (bus.axis_tlast) skip_n = 1'b0;
          end else begin
            take = 1'b1;
          end
        end
      end
      HC_CAPTURE: take = bus.beat_accept;
      HC_HOLD: begin
        if (bus.beat_accept) begin
          if (frame_open) begin
            if (bus.axis_tlast) frame_open_n = 1'b0;
          end else if (skip) begin
            if (bus.axis_tlast) skip_n = 1'b0;
          end else begin
            overrun_n = 1'b1;
            skip_n    = !bus.axis_tlast;
          end
        end
        if (valid_q && bus.hdr_ready) state_n = frame_open_n ? HC_DRAIN : HC_IDLE;
      end
      HC_DRAIN: begin
        if (bus.beat_accept && bus.axis_tlast) state_n = HC_IDLE;
      end
      default: state_n = HC_IDLE;
    endcase

    if (take) begin
      bytes_n = app_bytes_c;
      len_n   = app_len_c;
      short_n = 1'b0;
      if (app_len_c == LEN_W'(HDR_BYTES)) begin
        state_n      = HC_HOLD;
        frame_open_n = !bus.axis_tlast;
      end else if (bus.axis_tlast) begin
        state_n      = HC_HOLD;
        short_n      = 1'b1;
        frame_open_n = 1'b0;
      end else begin
        state_n = HC_CAPTURE;
      end
    end

    valid_n = (state_n == HC_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HC_IDLE;
      frame_open <= 1'b0;
      skip       <= 1'b0;
      bytes_q    <= '0;
      len_q      <= '0;
      short_q    <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_n;
      frame_open <= frame_open_n;
      skip       <= skip_n;
      bytes_q    <= bytes_n;
      len_q      <= len_n;
      short_q    <= short_n;
      valid_q    <= valid_n;
      overrun_q  <= overrun_n;
    end
  end

  assign bus.hdr_bytes   = bytes_q;
  assign bus.hdr_len     = len_q;
  assign bus.hdr_short   = short_q;
  assign bus.hdr_valid   = valid_q;
  assign bus.hdr_overrun = overrun_q;

endmodule
